// File: rtl/rob_multiway.sv
// Multi-way reorder buffer: in-order dispatch/retire, out-of-order CDB completion, branch flush.
// Define ROB_STORE_COMMIT_EN to add store-queue handshaking (at most one store retires per cycle).
module rob_multiway #(
   parameter int WAYS  = 3,
   parameter int DEPTH = 32,
   parameter int ARN_W = 5,
   parameter int PRN_W = 6,
   parameter int XLEN  = 32,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WAYS-1:0]            disp_valid_i,
   input  logic [WAYS-1:0][ARN_W-1:0] disp_arn_i,
   input  logic [WAYS-1:0][PRN_W-1:0] disp_prn_i,
   input  logic [WAYS-1:0]            disp_reg_write_i,
   input  logic [WAYS-1:0]            disp_is_branch_i,
   input  logic [WAYS-1:0][XLEN-1:0]  disp_pc_i,
   input  logic [WAYS-1:0]            disp_pred_taken_i,
   input  logic [WAYS-1:0][XLEN-1:0]  disp_pred_target_i,
   output logic                       disp_ready_o,
   output logic [WAYS-1:0][IDX_W-1:0] disp_idx_o,
   output logic [IDX_W:0]             free_cnt_o,
   input  logic [WAYS-1:0]            cdb_valid_i,
   input  logic [WAYS-1:0][IDX_W-1:0] cdb_idx_i,
   input  logic [WAYS-1:0]            cdb_taken_i,
   input  logic [WAYS-1:0][XLEN-1:0]  cdb_target_i,
`ifdef ROB_STORE_COMMIT_EN
   input  logic [WAYS-1:0]            disp_is_store_i,
   input  logic                       sq_commit_ready_i,
   output logic [WAYS-1:0]            commit_is_store_o,
`endif
   output logic [WAYS-1:0]            commit_valid_o,
   output logic [WAYS-1:0]            commit_reg_write_o,
   output logic [WAYS-1:0][ARN_W-1:0] commit_arn_o,
   output logic [WAYS-1:0][PRN_W-1:0] commit_prn_o,
   output logic                       flush_o,
   output logic [XLEN-1:0]            flush_pc_o
);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] head_q, tail_q, freeCnt_q;
   logic [DEPTH-1:0] valid_q, done_q, mispred_q, regWrite_q, isBranch_q, predTaken_q, resTaken_q;
   logic [ARN_W-1:0] arn_q [DEPTH];
   logic [PRN_W-1:0] prn_q [DEPTH];
   logic [XLEN-1:0]  pc_q [DEPTH];
   logic [XLEN-1:0]  predTarget_q [DEPTH];
   logic [XLEN-1:0]  resTarget_q [DEPTH];
`ifdef ROB_STORE_COMMIT_EN
   logic [DEPTH-1:0] isStore_q;
   logic             storeSeen;
`endif
   logic [PTR_W-1:0]           dispCnt, retireCnt;
   logic [WAYS-1:0][IDX_W-1:0] commitSlot;
   logic [WAYS-1:0]            commitValid;
   logic                       scanning, blocked, flush;
   logic [XLEN-1:0]            flushPc;

   assign free_cnt_o     = freeCnt_q;
   assign commit_valid_o = commitValid;
   assign flush_o        = flush;
   assign flush_pc_o     = flushPc;
   assign disp_ready_o   = (dispCnt <= freeCnt_q) && !flush;

   always_comb begin
      dispCnt = '0;
      for (int i = 0; i < WAYS; i++) begin
         dispCnt       = dispCnt + PTR_W'(disp_valid_i[i]);
         disp_idx_o[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
         commitSlot[i] = head_q[IDX_W-1:0] + IDX_W'(i);
      end
   end

   // Retire scan from head: stops at the first not-done entry and just after a mispredicted branch.
   always_comb begin
      commitValid = '0;
      retireCnt   = '0;
      flush       = 1'b0;
      flushPc     = '0;
      scanning    = 1'b1;
      blocked     = 1'b0;
`ifdef ROB_STORE_COMMIT_EN
      storeSeen   = 1'b0;
`endif
      for (int i = 0; i < WAYS; i++) begin
         blocked = !(valid_q[commitSlot[i]] && done_q[commitSlot[i]]);
`ifdef ROB_STORE_COMMIT_EN
         if (isStore_q[commitSlot[i]] && (storeSeen || !sq_commit_ready_i)) blocked = 1'b1;
`endif
         if (scanning && !blocked) begin
            commitValid[i] = 1'b1;
            retireCnt      = retireCnt + PTR_W'(1);
`ifdef ROB_STORE_COMMIT_EN
            if (isStore_q[commitSlot[i]]) storeSeen = 1'b1;
`endif
            if (mispred_q[commitSlot[i]]) begin
               flush    = 1'b1;
               flushPc  = resTaken_q[commitSlot[i]] ? resTarget_q[commitSlot[i]]
                                                    : pc_q[commitSlot[i]] + XLEN'(4);
               scanning = 1'b0;
            end
         end else begin
            scanning = 1'b0;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         commit_arn_o[i]       = arn_q[commitSlot[i]];
         commit_prn_o[i]       = prn_q[commitSlot[i]];
         commit_reg_write_o[i] = commitValid[i] & regWrite_q[commitSlot[i]];
`ifdef ROB_STORE_COMMIT_EN
         commit_is_store_o[i]  = commitValid[i] & isStore_q[commitSlot[i]];
`endif
      end
   end

   // CDB writes come first so a later way overrides an earlier one on the same index;
   // a flush wipes every entry and snaps tail back onto the post-retire head.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         freeCnt_q <= PTR_W'(DEPTH);
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            if (cdb_valid_i[w] && valid_q[cdb_idx_i[w]]) begin
               done_q[cdb_idx_i[w]]      <= 1'b1;
               resTaken_q[cdb_idx_i[w]]  <= cdb_taken_i[w];
               resTarget_q[cdb_idx_i[w]] <= cdb_target_i[w];
               mispred_q[cdb_idx_i[w]]   <= isBranch_q[cdb_idx_i[w]] &&
                  ((cdb_taken_i[w] != predTaken_q[cdb_idx_i[w]]) ||
                   (cdb_taken_i[w] && (cdb_target_i[w] != predTarget_q[cdb_idx_i[w]])));
            end
         end
         for (int i = 0; i < WAYS; i++) begin
            if (commitValid[i]) valid_q[commitSlot[i]] <= 1'b0;
         end
         head_q <= head_q + retireCnt;
         if (flush) begin
            valid_q   <= '0;
            tail_q    <= head_q + retireCnt;
            freeCnt_q <= PTR_W'(DEPTH);
         end else if (disp_ready_o) begin
            for (int i = 0; i < WAYS; i++) begin
               if (disp_valid_i[i]) begin
                  valid_q[disp_idx_o[i]]      <= 1'b1;
                  done_q[disp_idx_o[i]]       <= 1'b0;
                  mispred_q[disp_idx_o[i]]    <= 1'b0;
                  regWrite_q[disp_idx_o[i]]   <= disp_reg_write_i[i];
                  isBranch_q[disp_idx_o[i]]   <= disp_is_branch_i[i];
                  predTaken_q[disp_idx_o[i]]  <= disp_pred_taken_i[i];
                  predTarget_q[disp_idx_o[i]] <= disp_pred_target_i[i];
                  arn_q[disp_idx_o[i]]        <= disp_arn_i[i];
                  prn_q[disp_idx_o[i]]        <= disp_prn_i[i];
                  pc_q[disp_idx_o[i]]         <= disp_pc_i[i];
`ifdef ROB_STORE_COMMIT_EN
                  isStore_q[disp_idx_o[i]]    <= disp_is_store_i[i];
`endif
               end
            end
            tail_q    <= tail_q + dispCnt;
            freeCnt_q <= freeCnt_q - dispCnt + retireCnt;
         end else begin
            freeCnt_q <= freeCnt_q + retireCnt;
         end
      end
   end
endmodule

// File: tb/tb_rob_multiway.sv
// Self-checking bench for rob_multiway: directed scenarios plus random traffic against a queue model.
// The ROB_STORE_COMMIT_EN build also exercises the store-retire handshake.
module tb_rob_multiway;
   localparam int WAYS = 3, DEPTH = 32, ARN_W = 5, PRN_W = 6, XLEN = 32, IDX_W = 5;

   logic clock = 1'b0, reset = 1'b1;
   logic [WAYS-1:0]            dispValid, dispRegWrite, dispIsBranch, dispPredTaken;
   logic [WAYS-1:0][ARN_W-1:0] dispArn;
   logic [WAYS-1:0][PRN_W-1:0] dispPrn;
   logic [WAYS-1:0][XLEN-1:0]  dispPc, dispPredTarget;
   logic                       dispReady;
   logic [WAYS-1:0][IDX_W-1:0] dispIdx;
   logic [IDX_W:0]             freeCnt;
   logic [WAYS-1:0]            cdbValid, cdbTaken;
   logic [WAYS-1:0][IDX_W-1:0] cdbIdx;
   logic [WAYS-1:0][XLEN-1:0]  cdbTarget;
   logic [WAYS-1:0]            commitValid, commitRegWrite;
   logic [WAYS-1:0][ARN_W-1:0] commitArn;
   logic [WAYS-1:0][PRN_W-1:0] commitPrn;
   logic                       flush;
   logic [XLEN-1:0]            flushPc;
`ifdef ROB_STORE_COMMIT_EN
   logic [WAYS-1:0]            dispIsStore, commitIsStore;
   logic                       sqReady;
`endif

   typedef struct {
      logic [ARN_W-1:0] arn;
      logic [PRN_W-1:0] prn;
      bit               rw, br, pt, st, done, misp, rt;
      logic [XLEN-1:0]  pc, ptgt, rtgt;
   } ent_t;

   ent_t q[$];
   int   headPtr = 0;
   int   checks = 0, errors = 0;
   int   expK, expN;
   bit   expFl, expRdy;

   rob_multiway #(.WAYS(WAYS), .DEPTH(DEPTH), .ARN_W(ARN_W), .PRN_W(PRN_W), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset),
      .disp_valid_i(dispValid), .disp_arn_i(dispArn), .disp_prn_i(dispPrn),
      .disp_reg_write_i(dispRegWrite), .disp_is_branch_i(dispIsBranch), .disp_pc_i(dispPc),
      .disp_pred_taken_i(dispPredTaken), .disp_pred_target_i(dispPredTarget),
      .disp_ready_o(dispReady), .disp_idx_o(dispIdx), .free_cnt_o(freeCnt),
      .cdb_valid_i(cdbValid), .cdb_idx_i(cdbIdx), .cdb_taken_i(cdbTaken), .cdb_target_i(cdbTarget),
`ifdef ROB_STORE_COMMIT_EN
      .disp_is_store_i(dispIsStore), .sq_commit_ready_i(sqReady), .commit_is_store_o(commitIsStore),
`endif
      .commit_valid_o(commitValid), .commit_reg_write_o(commitRegWrite),
      .commit_arn_o(commitArn), .commit_prn_o(commitPrn), .flush_o(flush), .flush_pc_o(flushPc)
   );

   always #5 clock = ~clock;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clearInputs();
      dispValid = '0; dispRegWrite = '0; dispIsBranch = '0; dispPredTaken = '0;
      dispArn = '0; dispPrn = '0; dispPc = '0; dispPredTarget = '0;
      cdbValid = '0; cdbTaken = '0; cdbIdx = '0; cdbTarget = '0;
`ifdef ROB_STORE_COMMIT_EN
      dispIsStore = '0; sqReady = 1'b1;
`endif
   endtask

   task automatic dispSlot(input int i, input bit br, input bit pt, input logic [XLEN-1:0] tgt);
      dispValid[i] = 1'b1;
      dispArn[i] = ARN_W'($urandom); dispPrn[i] = PRN_W'($urandom);
      dispRegWrite[i] = 1'($urandom); dispPc[i] = $urandom & 32'hffff_fffc;
      dispIsBranch[i] = br; dispPredTaken[i] = pt; dispPredTarget[i] = tgt;
   endtask

   task automatic cdbAt(input int w, input int pos, input bit taken, input logic [XLEN-1:0] tgt);
      cdbValid[w] = 1'b1; cdbIdx[w] = IDX_W'((headPtr + pos) % DEPTH);
      cdbTaken[w] = taken; cdbTarget[w] = tgt;
   endtask

   // Completes up to n of the oldest unfinished entries with their predicted outcome.
   task automatic cdbOldest(input int n);
      int w = 0;
      for (int p = 0; p < q.size() && w < n; p++) begin
         if (!q[p].done) begin
            cdbAt(w, p, q[p].pt, q[p].ptgt);
            w++;
         end
      end
   endtask

   task automatic applyStimulus(input int nDisp, input int nCdb);
      bit br;
      clearInputs();
      for (int i = 0; i < nDisp; i++) begin
         br = ($urandom_range(0, 3) == 0);
         dispSlot(i, br, br ? 1'($urandom) : 1'b0, $urandom & 32'hffff_fffc);
`ifdef ROB_STORE_COMMIT_EN
         dispIsStore[i] = !br && ($urandom_range(0, 3) == 0);
`endif
      end
`ifdef ROB_STORE_COMMIT_EN
      sqReady = ($urandom_range(0, 3) != 0);
`endif
      for (int w = 0; w < nCdb; w++) begin
         if (q.size() == 0) break;
         if ($urandom_range(0, 7) == 0) begin
            cdbValid[w] = 1'b1; cdbIdx[w] = IDX_W'($urandom); cdbTaken[w] = 1'b0; cdbTarget[w] = '0;
         end else begin
            int pos = $urandom_range(0, q.size() - 1);
            if (q[pos].br && $urandom_range(0, 9) == 0)
               cdbAt(w, pos, !q[pos].pt, $urandom & 32'hffff_fffc);
            else
               cdbAt(w, pos, q[pos].pt, q[pos].ptgt);
         end
      end
   endtask

   // Samples at the falling edge and compares every output against the queue model.
   task automatic checkOutput();
      logic [WAYS-1:0] cv = '0;
      logic [XLEN-1:0] fpc = '0;
      bit stSeen = 1'b0;
      @(negedge clock);
      expN = 0; expK = 0; expFl = 1'b0;
      for (int i = 0; i < WAYS; i++) if (dispValid[i]) expN++;
      for (int i = 0; i < WAYS && i < q.size(); i++) begin
         if (!q[i].done) break;
`ifdef ROB_STORE_COMMIT_EN
         if (q[i].st && (stSeen || !sqReady)) break;
         if (q[i].st) stSeen = 1'b1;
`endif
         cv[i] = 1'b1; expK++;
         if (q[i].misp) begin
            expFl = 1'b1;
            fpc = q[i].rt ? q[i].rtgt : q[i].pc + 32'd4;
            break;
         end
      end
      expRdy = (expN <= DEPTH - q.size()) && !expFl;
      checkVal("free_cnt", freeCnt, DEPTH - q.size());
      checkVal("disp_ready", dispReady, expRdy);
      checkVal("commit_valid", commitValid, cv);
      checkVal("flush", flush, expFl);
      if (expFl) checkVal("flush_pc", flushPc, fpc);
      for (int i = 0; i < expK; i++) begin
         checkVal("commit_arn", commitArn[i], q[i].arn);
         checkVal("commit_prn", commitPrn[i], q[i].prn);
         checkVal("commit_reg_write", commitRegWrite[i], q[i].rw);
`ifdef ROB_STORE_COMMIT_EN
         checkVal("commit_is_store", commitIsStore[i], q[i].st);
`endif
      end
      if (expRdy)
         for (int i = 0; i < expN; i++) checkVal("disp_idx", dispIdx[i], (headPtr + q.size() + i) % DEPTH);
   endtask

   task automatic advanceCycle();
      ent_t e;
      for (int w = 0; w < WAYS; w++) begin
         int pos = (int'(cdbIdx[w]) - headPtr + DEPTH) % DEPTH;
         if (cdbValid[w] && pos < q.size()) begin
            e = q[pos];
            e.done = 1'b1; e.rt = cdbTaken[w]; e.rtgt = cdbTarget[w];
            e.misp = e.br && ((cdbTaken[w] != e.pt) || (cdbTaken[w] && cdbTarget[w] != e.ptgt));
            q[pos] = e;
         end
      end
      repeat (expK) void'(q.pop_front());
      headPtr = (headPtr + expK) % DEPTH;
      if (expFl) q.delete();
      else if (expRdy) begin
         for (int i = 0; i < expN; i++) begin
            e.arn = dispArn[i]; e.prn = dispPrn[i]; e.rw = dispRegWrite[i]; e.br = dispIsBranch[i];
            e.pt = dispPredTaken[i]; e.pc = dispPc[i]; e.ptgt = dispPredTarget[i];
            e.done = 1'b0; e.misp = 1'b0; e.rt = 1'b0; e.rtgt = '0; e.st = 1'b0;
`ifdef ROB_STORE_COMMIT_EN
            e.st = dispIsStore[i];
`endif
            q.push_back(e);
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic stepCycle();
      checkOutput();
      advanceCycle();
   endtask

   task automatic doReset();
      reset = 1'b1; clearInputs();
      @(posedge clock); #1;
      reset = 1'b0; q.delete(); headPtr = 0;
   endtask

   initial begin
      clearInputs();
      doReset();
      checkOutput();
      checkVal("reset_free_cnt", freeCnt, DEPTH);
      checkVal("reset_ready", dispReady, 1);
      advanceCycle();

      // Fill without completion until fewer than three slots remain.
      repeat (10) begin
         clearInputs();
         for (int i = 0; i < WAYS; i++) dispSlot(i, 1'b0, 1'b0, '0);
         stepCycle();
      end
      clearInputs();
      for (int i = 0; i < WAYS; i++) dispSlot(i, 1'b0, 1'b0, '0);
      checkOutput();
      checkVal("full_free_cnt", freeCnt, 2);
      checkVal("full_ready", dispReady, 0);
      advanceCycle();

      for (int c = 0; c < 40 && q.size() > 0; c++) begin
         clearInputs(); cdbOldest(WAYS); stepCycle();
      end
      checkVal("drain_empty", q.size(), 0);

      // Head now sits at 30: a three-wide group straddles the wrap.
      clearInputs();
      for (int i = 0; i < WAYS; i++) dispSlot(i, 1'b0, 1'b0, '0);
      checkOutput();
      checkVal("wrap_idx0", dispIdx[0], 30);
      checkVal("wrap_idx1", dispIdx[1], 31);
      checkVal("wrap_idx2", dispIdx[2], 0);
      advanceCycle();
      for (int p = 2; p >= 0; p--) begin
         clearInputs(); cdbAt(0, p, 1'b0, '0); stepCycle();
      end
      clearInputs();
      checkOutput();
      checkVal("group_retire", commitValid, 3'b111);
      advanceCycle();
      checkOutput();
      checkVal("wrap_free_cnt", freeCnt, DEPTH);
      checkVal("wrap_head", dispIdx[0], 1);
      advanceCycle();

      // Single mispredicted taken branch with a wrong target.
      clearInputs(); dispSlot(0, 1'b1, 1'b1, 32'h100); stepCycle();
      clearInputs(); cdbAt(0, 0, 1'b1, 32'h200); stepCycle();
      clearInputs();
      for (int i = 0; i < WAYS; i++) dispSlot(i, 1'b0, 1'b0, '0);
      checkOutput();
      checkVal("br_flush", flush, 1);
      checkVal("br_flush_pc", flushPc, 32'h200);
      checkVal("br_disp_drop", dispReady, 0);
      advanceCycle();
      clearInputs();
      checkOutput();
      checkVal("br_free_cnt", freeCnt, DEPTH);
      advanceCycle();

      // Mispredict in the middle of a completed group squashes the younger slot.
      clearInputs();
      dispSlot(0, 1'b0, 1'b0, '0); dispSlot(1, 1'b1, 1'b0, 32'h0); dispSlot(2, 1'b0, 1'b0, '0);
      stepCycle();
      clearInputs();
      cdbAt(0, 0, 1'b0, '0); cdbAt(1, 1, 1'b1, 32'h300); cdbAt(2, 2, 1'b0, '0);
      stepCycle();
      clearInputs();
      checkOutput();
      checkVal("mid_commit", commitValid, 3'b011);
      checkVal("mid_flush_pc", flushPc, 32'h300);
      advanceCycle();
      stepCycle();

`ifdef ROB_STORE_COMMIT_EN
      clearInputs();
      dispSlot(0, 1'b0, 1'b0, '0); dispSlot(1, 1'b0, 1'b0, '0); dispIsStore = 3'b011;
      stepCycle();
      clearInputs(); cdbAt(0, 0, 1'b0, '0); cdbAt(1, 1, 1'b0, '0); stepCycle();
      clearInputs(); sqReady = 1'b0;
      checkOutput();
      checkVal("st_blocked", commitValid, 3'b000);
      advanceCycle();
      clearInputs();
      checkOutput();
      checkVal("st_first", commitValid, 3'b001);
      advanceCycle();
      checkOutput();
      checkVal("st_second", commitValid, 3'b001);
      advanceCycle();
`endif

      repeat (400) begin
         applyStimulus($urandom_range(0, WAYS), $urandom_range(0, WAYS));
         stepCycle();
      end

      // Reset in the middle of traffic discards everything.
      repeat (5) begin
         applyStimulus(WAYS, 1);
         stepCycle();
      end
      doReset();
      checkOutput();
      checkVal("mid_reset_free", freeCnt, DEPTH);
      checkVal("mid_reset_commit", commitValid, 0);
      checkVal("mid_reset_idx", dispIdx[0], 0);
      advanceCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
